// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered framebuffer.
// Holds the clear FSM states, the page count and the {page, addr} builder.
package fb_pkg;

  localparam int PAGE_COUNT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } clr_state_t;

  // Builds the physical RAM address {page, addr}; the caller casts to its width.
  function automatic logic [31:0] page_addr(input logic page,
                                            input logic [30:0] addr,
                                            input int aw);
    logic [31:0] r_pa;
    r_pa = {31'd0, page} << aw;
    r_pa = r_pa | {1'b0, addr};
    return r_pa;
  endfunction

endpackage

// File: rtl/framebuffer_dbuf_if.sv
// Pixel write/read, swap and clear-engine signals of the framebuffer.
// master drives requests, slave (the framebuffer) answers.
interface framebuffer_dbuf_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
);
  logic                  en_wr;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_drop;
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  swap_req;
  logic                  vsync;
  logic                  swap_pending;
  logic                  front_sel;
  logic                  clear_start;
  logic [DATA_WIDTH-1:0] clear_color;
  logic                  clear_busy;
  logic                  clear_done;

  modport master (
    output en_wr, addr_wr, din, en_rd, addr_rd, swap_req, vsync,
           clear_start, clear_color,
    input  wr_drop, dout, dout_valid, swap_pending, front_sel,
           clear_busy, clear_done
  );

  modport slave (
    input  en_wr, addr_wr, din, en_rd, addr_rd, swap_req, vsync,
           clear_start, clear_color,
    output wr_drop, dout, dout_valid, swap_pending, front_sel,
           clear_busy, clear_done
  );
endinterface

// File: rtl/fb_sdp_ram.sv
// Single-clock simple dual-port RAM with registered read.
// Only the read data/valid registers are reset; the array keeps its contents.
module fb_sdp_ram #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_rvalid
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered framebuffer: vsync-gated page swap, back-page clear engine
// and write arbitration in front of a two-page simple dual-port RAM.
module framebuffer_dbuf
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
) (
  input  logic clk,
  input  logic rst,
  framebuffer_dbuf_if.slave bus
);

  localparam int PA_W = ADDR_WIDTH + $clog2(PAGE_COUNT);

  clr_state_t            r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0] r_color, w_color_nx;
  logic                  r_page, w_page_nx;
  logic                  w_busy, w_done;

  logic                  r_front, r_pend, r_wr_drop;
  logic                  w_pend_nx;

  logic                  w_we;
  logic [PA_W-1:0]       w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_page  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_color <= w_color_nx;
      r_page  <= w_page_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_color_nx = r_color;
    w_page_nx  = r_page;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.clear_start) begin
          w_color_nx = bus.clear_color;
          w_page_nx  = ~r_front;
          w_cnt_nx   = '0;
          w_state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        w_busy   = 1'b1;
        w_cnt_nx = r_cnt + ADDR_WIDTH'(1);
        if (&r_cnt) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        w_done     = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // The fill owns the write port; external writes are dropped while it runs.
  always_comb begin
    w_we    = w_busy | bus.en_wr;
    w_wdata = w_busy ? r_color : bus.din;
    w_waddr = w_busy ? PA_W'(page_addr(r_page, 31'(r_cnt), ADDR_WIDTH))
                     : PA_W'(page_addr(~r_front, 31'(bus.addr_wr), ADDR_WIDTH));
    w_raddr = PA_W'(page_addr(r_front, 31'(bus.addr_rd), ADDR_WIDTH));
  end

  assign w_pend_nx = r_pend | bus.swap_req;

  // Swapping mid-fill would expose a half-cleared page, so vsync waits for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_front   <= 1'b0;
      r_pend    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= bus.en_wr & w_busy;
      if (bus.vsync && w_pend_nx && !w_busy) begin
        r_front <= ~r_front;
        r_pend  <= 1'b0;
      end else begin
        r_pend  <= w_pend_nx;
      end
    end
  end

  fb_sdp_ram #(
    .ADDR_WIDTH (PA_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_re     (bus.en_rd),
    .i_raddr  (w_raddr),
    .o_rdata  (bus.dout),
    .o_rvalid (bus.dout_valid)
  );

  assign bus.wr_drop      = r_wr_drop;
  assign bus.swap_pending = r_pend;
  assign bus.front_sel    = r_front;
  assign bus.clear_busy   = w_busy;
  assign bus.clear_done   = w_done;

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Self-checking bench for framebuffer_dbuf: directed scenarios plus random
// traffic, checked every cycle against a page/array reference model.
module tb_framebuffer_dbuf;

  localparam int AW   = 4;
  localparam int DW   = 12;
  localparam int NPIX = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  framebuffer_dbuf_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  framebuffer_dbuf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: memory as a flat array indexed page*NPIX + addr.
  logic [DW-1:0] m_mem   [2*NPIX];
  bit            m_known [2*NPIX];
  bit            m_front, m_pend, m_done, m_wr_drop, m_valid, m_dout_known;
  int            m_fill_left;
  bit            m_cpage;
  logic [DW-1:0] m_ccolor, m_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic set_idle();
    bus.en_wr = 0; bus.addr_wr = '0; bus.din = '0;
    bus.en_rd = 0; bus.addr_rd = '0;
    bus.swap_req = 0; bus.vsync = 0;
    bus.clear_start = 0; bus.clear_color = '0;
  endtask

  task automatic model_reset();
    m_front = 0; m_pend = 0; m_done = 0; m_wr_drop = 0; m_valid = 0;
    m_fill_left = 0; m_dout = '0; m_dout_known = 1;
  endtask

  task automatic model_update();
    bit busy, was_done, pn;
    int idx;
    busy     = (m_fill_left > 0);
    was_done = m_done;
    if (bus.en_rd) begin
      idx = (m_front ? NPIX : 0) + int'(bus.addr_rd);
      m_dout = m_mem[idx]; m_dout_known = m_known[idx]; m_valid = 1;
    end else m_valid = 0;
    m_wr_drop = bus.en_wr && busy;
    m_done    = busy && (m_fill_left == 1);
    if (busy) begin
      idx = (m_cpage ? NPIX : 0) + (NPIX - m_fill_left);
      m_mem[idx] = m_ccolor; m_known[idx] = 1;
      m_fill_left--;
    end else if (bus.en_wr) begin
      idx = (m_front ? 0 : NPIX) + int'(bus.addr_wr);
      m_mem[idx] = bus.din; m_known[idx] = 1;
    end
    if (!busy && !was_done && bus.clear_start) begin
      m_fill_left = NPIX; m_cpage = !m_front; m_ccolor = bus.clear_color;
    end
    pn = m_pend || bus.swap_req;
    if (bus.vsync && pn && !busy) begin
      m_front = !m_front; m_pend = 0;
    end else m_pend = pn;
  endtask

  task automatic compare();
    chk("front_sel",    32'(bus.front_sel),    32'(m_front));
    chk("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
    chk("clear_busy",   32'(bus.clear_busy),   32'(m_fill_left > 0));
    chk("clear_done",   32'(bus.clear_done),   32'(m_done));
    chk("wr_drop",      32'(bus.wr_drop),      32'(m_wr_drop));
    chk("dout_valid",   32'(bus.dout_valid),   32'(m_valid));
    if (m_dout_known) chk("dout", 32'(bus.dout), 32'(m_dout));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    #1 rst = 1'b0;
  endtask

  task automatic run_clear(input logic [DW-1:0] color, input string tag);
    int busy_cycles;
    bit seen;
    busy_cycles = 0; seen = 0;
    bus.clear_start = 1; bus.clear_color = color;
    step();
    set_idle();
    if (bus.clear_busy) busy_cycles++;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.clear_busy) busy_cycles++;
      if (bus.clear_done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), NPIX);
  endtask

  initial begin
    bit done_seen;
    for (int i = 0; i < 2*NPIX; i++) begin m_mem[i] = '0; m_known[i] = 0; end
    set_idle();
    model_reset();
    #1 compare();
    @(posedge clk); #1 compare();
    rst = 1'b0;

    // 1: write back page, swap, read it from the front
    bus.en_wr = 1; bus.addr_wr = 4'd3; bus.din = 12'hABC; step(); set_idle();
    bus.swap_req = 1; step(); set_idle();
    chk("s1_pending", 32'(bus.swap_pending), 32'd1);
    bus.vsync = 1; step(); set_idle();
    chk("s1_front", 32'(bus.front_sel), 32'd1);
    bus.en_rd = 1; bus.addr_rd = 4'd3; step(); set_idle();
    chk("s1_dout", 32'(bus.dout), 32'hABC);
    chk("s1_valid", 32'(bus.dout_valid), 32'd1);

    // 2: pending swap held without vsync, then immediate swap_req+vsync
    bus.swap_req = 1; step(); set_idle();
    repeat (5) step();
    chk("s2_pending_held", 32'(bus.swap_pending), 32'd1);
    chk("s2_front_held", 32'(bus.front_sel), 32'd1);
    bus.swap_req = 1; bus.vsync = 1; step(); set_idle();
    chk("s2_front_toggle", 32'(bus.front_sel), 32'd0);
    chk("s2_pending_clr", 32'(bus.swap_pending), 32'd0);

    // 3: clear back page, swap, read it all back
    run_clear(12'h0F0, "s3");
    bus.swap_req = 1; bus.vsync = 1; step(); set_idle();
    for (int a = 0; a < NPIX; a++) begin
      bus.en_rd = 1; bus.addr_rd = AW'(a); step();
      chk("s3_fill_rd", 32'(bus.dout), 32'h0F0);
    end
    set_idle(); step();

    // 4: writes dropped and vsync deferred while the fill runs
    bus.swap_req = 1; step(); set_idle();
    bus.clear_start = 1; bus.clear_color = 12'h555; step(); set_idle();
    done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (i == 2) begin bus.en_wr = 1; bus.addr_wr = 4'd5; bus.din = 12'h123; end
      if (i == 6) bus.vsync = 1;
      step(); set_idle();
      if (i == 2) chk("s4_wr_drop", 32'(bus.wr_drop), 32'd1);
      if (i == 6) chk("s4_no_swap", 32'(bus.front_sel), 32'd1);
      if (bus.clear_done) done_seen = 1;
    end
    chk("s4_done_seen", 32'(done_seen), 32'd1);
    bus.vsync = 1; step(); set_idle();
    chk("s4_swap_after", 32'(bus.front_sel), 32'd0);
    bus.en_rd = 1; bus.addr_rd = 4'd5; step(); set_idle();
    chk("s4_clear_wins", 32'(bus.dout), 32'h555);

    // 5: async reset during the fill, then a full clean fill
    bus.clear_start = 1; bus.clear_color = 12'h777; step(); set_idle();
    repeat (6) step();
    async_reset();
    chk("s5_busy_rst", 32'(bus.clear_busy), 32'd0);
    run_clear(12'h0AA, "s5");

    // 6: streaming reads of the front page while writing the back page
    bus.swap_req = 1; bus.vsync = 1; step(); set_idle();
    for (int a = 0; a < NPIX; a++) begin
      bus.en_rd = 1; bus.addr_rd = AW'(a);
      bus.en_wr = 1; bus.addr_wr = AW'($urandom_range(0, NPIX-1)); bus.din = DW'($urandom);
      step();
      chk("s6_stream_valid", 32'(bus.dout_valid), 32'd1);
      chk("s6_front_data", 32'(bus.dout), 32'h0AA);
    end
    set_idle(); step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.en_wr       = ($urandom_range(0, 1) == 1);
      bus.addr_wr     = AW'($urandom);
      bus.din         = DW'($urandom);
      bus.en_rd       = ($urandom_range(0, 2) != 0);
      bus.addr_rd     = AW'($urandom);
      bus.swap_req    = ($urandom_range(0, 9) == 0);
      bus.vsync       = ($urandom_range(0, 11) == 0);
      bus.clear_start = ($urandom_range(0, 39) == 0);
      bus.clear_color = DW'($urandom);
      step();
    end
    set_idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
